// File: rtl/uart_pkg.sv
// Shared UART constants: data width, default bit timing, frame length and the
// default receive-idle timeout derived from them.
package uart_pkg;

   localparam int UART_DATA_W      = 8;
   localparam int CLKS_PER_BIT     = 217;
   localparam int UART_FRAME_BITS  = 10;
   localparam int UART_IDLE_CHARS  = 4;

   // Idle clocks spanning a number of character times at a given bit rate.
   function automatic int idle_clks(input int chars, input int frame_bits,
                                    input int clks_per_bit);
      return chars * frame_bits * clks_per_bit;
   endfunction

   localparam int UART_TIMEOUT_CLKS =
      idle_clks(UART_IDLE_CHARS, UART_FRAME_BITS, CLKS_PER_BIT);

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the receive FIFO: one synchronous write port and one
// asynchronous read port. Storage is deliberately not reset.
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                   i_Clock,
   input  logic                   we,
   input  logic [AW-1:0]          waddr,
   input  logic [UART_DATA_W-1:0] wdata,
   input  logic [AW-1:0]          raddr,
   output logic [UART_DATA_W-1:0] rdata
);

   logic [UART_DATA_W-1:0] mem [DEPTH];

   // Write the incoming byte into its slot on the clock edge.
   always_ff @(posedge i_Clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side first-word-fall-through FIFO behind the UART receiver, with
// level, overrun, threshold and idle-timeout status.
// Optional feature: define UART_RX_FIFO_TIMEOUT_EN to build the idle-timeout
// counter; otherwise o_Timeout_Irq is held low.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH        = 16,
   parameter int THRESH       = 8,
   parameter int TIMEOUT_CLKS = UART_TIMEOUT_CLKS
) (
   input  logic                     i_Clock,
   input  logic                     i_Rst_L,
   input  logic                     i_RX_DV,
   input  logic [UART_DATA_W-1:0]   i_RX_Byte,
   input  logic                     i_Rd_En,
   input  logic                     i_Clr_Overrun,
   output logic [UART_DATA_W-1:0]   o_Rd_Data,
   output logic                     o_Empty,
   output logic                     o_Full,
   output logic [$clog2(DEPTH):0]   o_Count,
   output logic                     o_Overrun,
   output logic                     o_Thresh_Irq,
   output logic                     o_Timeout_Irq
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic [CW-1:0]          count_q;
   logic [CW-1:0]          count_nxt;
   logic                   empty_q;
   logic                   full_q;
   logic                   overrun_q;
   logic                   thresh_q;
   logic                   push_ok;
   logic                   pop_ok;
   logic                   overrun_set;
   logic [UART_DATA_W-1:0] mem_rdata;

   // A push is accepted while full only if a pop frees the head slot in the
   // same cycle; the write then lands in the slot being vacated.
   always_comb begin
      pop_ok      = i_Rd_En && !empty_q;
      push_ok     = i_RX_DV && (!full_q || pop_ok);
      overrun_set = i_RX_DV && full_q && !pop_ok;
      count_nxt   = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_nxt = count_q + CW'(1);
         2'b01:   count_nxt = count_q - CW'(1);
         default: count_nxt = count_q;
      endcase
   end

   // Pointers, occupancy and level flags all update on the same edge.
   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         thresh_q <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         count_q  <= count_nxt;
         empty_q  <= (count_nxt == '0);
         full_q   <= (count_nxt == CW'(DEPTH));
         thresh_q <= (count_nxt >= CW'(THRESH));
      end
   end

   // Sticky overrun flag; a new overrun outranks a simultaneous clear.
   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         overrun_q <= 1'b0;
      end else if (overrun_set) begin
         overrun_q <= 1'b1;
      end else if (i_Clr_Overrun) begin
         overrun_q <= 1'b0;
      end
   end

   uart_fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .i_Clock (i_Clock),
      .we      (push_ok),
      .waddr   (wr_ptr),
      .wdata   (i_RX_Byte),
      .raddr   (rd_ptr),
      .rdata   (mem_rdata)
   );

   assign o_Rd_Data    = empty_q ? '0 : mem_rdata;
   assign o_Empty      = empty_q;
   assign o_Full       = full_q;
   assign o_Count      = count_q;
   assign o_Overrun    = overrun_q;
   assign o_Thresh_Irq = thresh_q;

`ifdef UART_RX_FIFO_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CLKS + 1);

   logic [TW-1:0] idle_cnt;

   // Count idle clocks while data sits unread; any traffic or an empty FIFO
   // restarts it, and it parks at the limit.
   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         idle_cnt <= '0;
      end else if (push_ok || pop_ok || empty_q) begin
         idle_cnt <= '0;
      end else if (idle_cnt != TW'(TIMEOUT_CLKS)) begin
         idle_cnt <= idle_cnt + TW'(1);
      end
   end

   assign o_Timeout_Irq = (idle_cnt == TW'(TIMEOUT_CLKS)) && !empty_q;
`else
   // Feature absent: constant low, still expressed through TIMEOUT_CLKS so the
   // parameter is referenced in both builds.
   assign o_Timeout_Irq = (TIMEOUT_CLKS < 0);
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH 16, THRESH 8,
// TIMEOUT_CLKS 20).
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;
   localparam int THRESH = 8;
   localparam int TOUT = 20;

   logic       clk = 1'b0;
   logic       rst_l = 1'b0;
   logic       rx_dv = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic       rd_en = 1'b0;
   logic       clr_ovr = 1'b0;
   logic [7:0] rd_data;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       overrun;
   logic       thresh_irq;
   logic       tout_irq;

   int n_checks = 0;
   int n_fail = 0;
`ifdef UART_RX_FIFO_TIMEOUT_EN
   localparam logic TOUT_EN = 1'b1;
`else
   localparam logic TOUT_EN = 1'b0;
`endif

   uart_rx_fifo #(
      .DEPTH        (DEPTH),
      .THRESH       (THRESH),
      .TIMEOUT_CLKS (TOUT)
   ) dut (
      .i_Clock       (clk),
      .i_Rst_L       (rst_l),
      .i_RX_DV       (rx_dv),
      .i_RX_Byte     (rx_byte),
      .i_Rd_En       (rd_en),
      .i_Clr_Overrun (clr_ovr),
      .o_Rd_Data     (rd_data),
      .o_Empty       (empty),
      .o_Full        (full),
      .o_Count       (count),
      .o_Overrun     (overrun),
      .o_Thresh_Irq  (thresh_irq),
      .o_Timeout_Irq (tout_irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // One clock with the current inputs, then release strobes 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
      rx_dv   = 1'b0;
      rd_en   = 1'b0;
      clr_ovr = 1'b0;
   endtask

   task automatic push(input logic [7:0] b);
      rx_dv = 1'b1;
      rx_byte = b;
      tick();
   endtask

   task automatic pop();
      rd_en = 1'b1;
      tick();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " empty"}, 32'(empty), 32'd1);
      check({tag, " full"}, 32'(full), 32'd0);
      check({tag, " count"}, 32'(count), 32'd0);
      check({tag, " rd_data"}, 32'(rd_data), 32'h00);
      check({tag, " overrun"}, 32'(overrun), 32'd0);
      check({tag, " thresh"}, 32'(thresh_irq), 32'd0);
      check({tag, " timeout"}, 32'(tout_irq), 32'd0);
   endtask

   initial begin
      // Reset held, then released 1 ns after an edge.
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      rst_l = 1'b1;
      tick();

      // Single byte in and out.
      push(8'hA5);
      check("one empty", 32'(empty), 32'd0);
      check("one count", 32'(count), 32'd1);
      check("one data", 32'(rd_data), 32'hA5);
      pop();
      check("one pop empty", 32'(empty), 32'd1);
      check("one pop data", 32'(rd_data), 32'h00);
      check("one pop count", 32'(count), 32'd0);

      // Fill with 0x00..0x0F; threshold from the 8th push, full at 16th.
      for (int i = 0; i < DEPTH; i++) begin
         push(8'(i));
         check($sformatf("fill%0d count", i), 32'(count), 32'(i + 1));
         check($sformatf("fill%0d thresh", i), 32'(thresh_irq),
               32'((i + 1) >= THRESH));
         check($sformatf("fill%0d full", i), 32'(full), 32'(i == DEPTH - 1));
      end
      check("fill head", 32'(rd_data), 32'h00);

      // Overrun while full: byte dropped, flag set, count held.
      push(8'h55);
      check("ovr flag", 32'(overrun), 32'd1);
      check("ovr count", 32'(count), 32'd16);
      check("ovr head", 32'(rd_data), 32'h00);
      clr_ovr = 1'b1;
      tick();
      check("ovr clr", 32'(overrun), 32'd0);
      rx_dv = 1'b1;
      rx_byte = 8'h66;
      clr_ovr = 1'b1;
      tick();
      check("ovr set wins", 32'(overrun), 32'd1);
      clr_ovr = 1'b1;
      tick();
      check("ovr clr2", 32'(overrun), 32'd0);

      // Full with push and pop together: no overrun, count held.
      rx_dv = 1'b1;
      rx_byte = 8'h77;
      rd_en = 1'b1;
      tick();
      check("fullpp count", 32'(count), 32'd16);
      check("fullpp ovr", 32'(overrun), 32'd0);
      check("fullpp full", 32'(full), 32'd1);

      // Drain: 0x01..0x0F then 0x77; 0x55 and 0x66 never appear.
      for (int i = 1; i < DEPTH; i++) begin
         check($sformatf("drain%0d", i), 32'(rd_data), 32'(i));
         pop();
      end
      check("drain last", 32'(rd_data), 32'h77);
      pop();
      check("drain empty", 32'(empty), 32'd1);
      check("drain count", 32'(count), 32'd0);

      // Second fill across the pointer wrap.
      for (int i = 0; i < DEPTH; i++) push(8'hF0 | 8'(i));
      check("refill full", 32'(full), 32'd1);
      for (int i = 0; i < DEPTH; i++) begin
         check($sformatf("refill%0d", i), 32'(rd_data), 32'(8'hF0 | 8'(i)));
         pop();
      end
      check("refill empty", 32'(empty), 32'd1);

      // Empty with push and pop together: only the push happens.
      rx_dv = 1'b1;
      rx_byte = 8'h3C;
      rd_en = 1'b1;
      tick();
      check("emptypp count", 32'(count), 32'd1);
      check("emptypp data", 32'(rd_data), 32'h3C);

      // Idle timeout after TOUT clocks with one byte waiting.
      repeat (TOUT - 1) tick();
      check("tout early", 32'(tout_irq), 32'd0);
      tick();
      check("tout fire", 32'(tout_irq), 32'(TOUT_EN));
      repeat (3) tick();
      check("tout hold", 32'(tout_irq), 32'(TOUT_EN));
      pop();
      check("tout clear", 32'(tout_irq), 32'd0);

      // Pop while empty is ignored.
      pop();
      check("epop count", 32'(count), 32'd0);
      check("epop empty", 32'(empty), 32'd1);
      check("epop data", 32'(rd_data), 32'h00);

      // Asynchronous reset mid-fill at count 5.
      for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
      check("mid count", 32'(count), 32'd5);
      #2;
      rst_l = 1'b0;
      #1;
      check_reset_vals("async rst");
      @(posedge clk);
      #1;
      rst_l = 1'b1;
      push(8'h9A);
      check("post rst data", 32'(rd_data), 32'h9A);
      check("post rst count", 32'(count), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver. It captures every byte presented on the receiver's one-cycle data-valid strobe into a first-word-fall-through FIFO. The APB register interface drains it with a pop strobe. The block also reports level, overrun, threshold and (optionally) idle-timeout status for interrupt generation.

## Interface
- DEPTH, 16: FIFO entries; power of two, ≥ 2.
- THRESH, 8: level at or above which o_Thresh_Irq asserts; 1..DEPTH.
- TIMEOUT_CLKS, 8680: idle clocks before timeout (4 characters × 10 bits × 217 clocks/bit).
- i_Clock  in  1  system clock, all logic rising-edge.
- i_Rst_L  in  1  asynchronous, active-low reset.
- i_RX_DV  in  1  one-cycle strobe from the receiver; byte is valid this cycle.
- i_RX_Byte  in  8  received byte, qualified by i_RX_DV.
- i_Rd_En  in  1  pop request from the register interface.
- i_Clr_Overrun  in  1  clears o_Overrun.
- o_Rd_Data  out  8  head entry; 8'h00 while o_Empty.
- o_Empty  out  1  FIFO holds 0 entries.
- o_Full  out  1  FIFO holds DEPTH entries.
- o_Count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- o_Overrun  out  1  sticky flag: a byte was dropped.
- o_Thresh_Irq  out  1  level interrupt, o_Count ≥ THRESH.
- o_Timeout_Irq  out  1  level interrupt, data stale for TIMEOUT_CLKS.

## Operation
- Storage: DEPTH × 8 array; write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. A separate occupancy counter drives o_Count, o_Empty and o_Full.
- Push: i_RX_DV=1 and not full → write i_RX_Byte at the write pointer, advance it.
- Pop: i_Rd_En=1 and not empty → advance the read pointer. A pop while empty is ignored: no pointer change, no error.
- Push and pop in the same cycle:
  - Not empty and not full: both occur; count unchanged.
  - Empty: only the push occurs; count becomes 1.
  - Full: both occur; count stays DEPTH; no overrun.
- Overrun: i_RX_DV=1 while full with no pop in that cycle → byte discarded, o_Overrun set. The flag stays set until i_Clr_Overrun. If set and clear land in the same cycle, set wins.
- o_Thresh_Irq = (o_Count ≥ THRESH), registered from next-state count.
- Reset (async assert, sync release): pointers 0, o_Count 0, o_Empty 1, o_Full 0, o_Rd_Data 8'h00, o_Overrun 0, both IRQs 0. Any byte arriving during reset is lost.

## Timing
- Push at edge N: o_Empty falls, o_Count increments and o_Rd_Data shows the byte after edge N, so it is visible in cycle N+1.
- o_Rd_Data is combinational from the array at the read pointer, gated to 00 when empty. The next entry is visible the cycle after a pop.
- All flags are registered and update on the same edge as the pointer change. There is no extra latency.
- Back-to-back pops every cycle are supported. The receiver cannot push more often than once per CLEANUP cycle, but the FIFO accepts a push every cycle.

## Configuration
- UART_RX_FIFO_TIMEOUT_EN defined:
  - An idle counter of $clog2(TIMEOUT_CLKS+1) bits resets to 0 on any push, any successful pop, or when empty.
  - Otherwise it increments each cycle, saturating at TIMEOUT_CLKS.
  - o_Timeout_Irq = (counter == TIMEOUT_CLKS) and not empty.
  - It clears the cycle after the next push or pop.
- Undefined: no counter logic; o_Timeout_Irq tied 0.

## Structure
- Shared package uart_pkg holds:
  - UART_DATA_W = 8
  - default CLKS_PER_BIT = 217
  - UART_FRAME_BITS = 10
  - the TIMEOUT_CLKS default expression
- One sub-module, uart_fifo_mem:
  - DEPTH × UART_DATA_W array, one synchronous write port, one asynchronous read port.
  - No reset on storage.
- Pointer, count, flag and timeout logic stays in uart_rx_fifo.

## Test plan
- Reset then push 8'hA5 → next cycle o_Empty=0, o_Count=1, o_Rd_Data=A5; pop → o_Empty=1, o_Rd_Data=00.
- Push 16 bytes 0x00..0x0F → o_Full=1, o_Thresh_Irq=1 from the 8th push; 16 pops return 0x00..0x0F in order; pointers wrap cleanly on a second fill.
- Full, push 0x55 with no pop → o_Overrun=1, count stays 16, 0x55 never read; i_Clr_Overrun → 0; clear together with a new overrun → stays 1.
- Full, push 0x77 and pop in the same cycle → count 16, o_Overrun=0, 0x77 read last; empty with push and pop together → count 1.
- Pop on empty → no change, o_Count=0; assert i_Rst_L low mid-fill at count 5 → all outputs to reset values immediately.
- With UART_RX_FIFO_TIMEOUT_EN and TIMEOUT_CLKS=20: push 1 byte, idle 20 clocks → o_Timeout_Irq=1; pop → 0 next cycle; without the macro it stays 0.
